// File: rtl/regfile_port_sched.sv
// ============================================================================
// regfile_port_sched: register-file write-port scheduler (commit / debug / rollback)
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_port_sched #(
  parameter int DBG_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         rob_commit,
  input  logic [4:0]                   rob_commit_rd,
  input  logic [31:0]                  rob_commit_val,
  input  logic [3:0]                   rob_commit_pos,
  input  logic                         rob_empty,
  input  logic                         rollback_req,
  input  logic                         dec_issue,
  input  logic [4:0]                   dec_issue_rd,
  input  logic [3:0]                   dec_issue_rob_pos,
  output logic                         dec_stall,
  input  logic                         dbg_wr_valid,
  output logic                         dbg_wr_ready,
  input  logic [4:0]                   dbg_wr_rd,
  input  logic [31:0]                  dbg_wr_val,
  output logic [$clog2(DBG_DEPTH):0]   dbg_count,
  output logic                         rf_commit,
  output logic [4:0]                   rf_commit_rd,
  output logic [31:0]                  rf_commit_val,
  output logic [3:0]                   rf_commit_rob_pos,
  output logic                         rf_issue,
  output logic [4:0]                   rf_issue_rd,
  output logic [3:0]                   rf_issue_rob_pos,
  output logic                         rf_rollback
);

  localparam int c_addr_w = $clog2(DBG_DEPTH);
  localparam int c_cnt_w  = c_addr_w + 1;
  localparam int c_fl_w   = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DBG      = 2'd1,
    S_ROLLBACK = 2'd2,
    S_FLUSH    = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_fl_w-1:0]   r_flush_cnt, w_flush_cnt_nxt;
  logic [c_addr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic [4:0]          r_mem_rd  [DBG_DEPTH];
  logic [31:0]         r_mem_val [DBG_DEPTH];

  logic w_active, w_nonempty, w_push, w_store, w_pop;

  // Both reset and a global stall freeze the block and close every port.
  assign w_active   = rst & rdy;
  assign w_nonempty = (r_count != '0);

  assign dbg_wr_ready = w_active & (r_count < c_cnt_w'(DBG_DEPTH));
  assign w_push       = dbg_wr_valid & dbg_wr_ready;
  assign w_store      = w_push & (dbg_wr_rd != 5'd0);
  assign w_pop        = w_active & (r_state == S_DBG) & ~rob_commit & rob_empty & w_nonempty;
  assign dbg_count    = r_count;

  assign dec_stall        = ~w_active | (r_state != S_IDLE) | rollback_req | w_nonempty;
  assign rf_issue         = dec_issue & ~dec_stall;
  assign rf_issue_rd      = dec_issue_rd;
  assign rf_issue_rob_pos = dec_issue_rob_pos;

  // ROB commits always win the port; debug drains use tag 0, which is never live when the ROB is empty.
  assign rf_commit         = w_active & (rob_commit | w_pop);
  assign rf_commit_rd      = rob_commit ? rob_commit_rd  : r_mem_rd[r_rd_ptr];
  assign rf_commit_val     = rob_commit ? rob_commit_val : r_mem_val[r_rd_ptr];
  assign rf_commit_rob_pos = rob_commit ? rob_commit_pos : 4'd0;

  assign rf_rollback = w_active & (r_state == S_ROLLBACK);

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_nonempty) w_state_nxt = S_DBG;
      end
      S_DBG: begin
        if (w_pop && !w_store && (r_count == c_cnt_w'(1))) w_state_nxt = S_IDLE;
      end
      S_ROLLBACK: begin
        w_flush_cnt_nxt = c_fl_w'(FLUSH_CYCLES);
        w_state_nxt     = (FLUSH_CYCLES == 0) ? S_IDLE : S_FLUSH;
      end
      S_FLUSH: begin
        w_flush_cnt_nxt = r_flush_cnt - c_fl_w'(1);
        if (r_flush_cnt <= c_fl_w'(1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rollback_req) w_state_nxt = S_ROLLBACK;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else if (rdy) begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      if (w_store) r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      if (w_store && !w_pop)      r_count <= r_count + c_cnt_w'(1);
      else if (!w_store && w_pop) r_count <= r_count - c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem_rd[r_wr_ptr]  <= dbg_wr_rd;
      r_mem_val[r_wr_ptr] <= dbg_wr_val;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_port_sched.sv
// ============================================================================
// tb_regfile_port_sched: directed scoreboard bench for regfile_port_sched
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_port_sched;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        rob_commit, rob_empty, rollback_req, dec_issue, dbg_wr_valid;
  logic [4:0]  rob_commit_rd, dec_issue_rd, dbg_wr_rd;
  logic [31:0] rob_commit_val, dbg_wr_val;
  logic [3:0]  rob_commit_pos, dec_issue_rob_pos;
  logic        dec_stall, dbg_wr_ready, rf_commit, rf_issue, rf_rollback;
  logic [2:0]  dbg_count;
  logic [4:0]  rf_commit_rd, rf_issue_rd;
  logic [31:0] rf_commit_val;
  logic [3:0]  rf_commit_rob_pos, rf_issue_rob_pos;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  pos;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  regfile_port_sched #(.DBG_DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rob_commit(rob_commit), .rob_commit_rd(rob_commit_rd),
    .rob_commit_val(rob_commit_val), .rob_commit_pos(rob_commit_pos),
    .rob_empty(rob_empty), .rollback_req(rollback_req),
    .dec_issue(dec_issue), .dec_issue_rd(dec_issue_rd),
    .dec_issue_rob_pos(dec_issue_rob_pos), .dec_stall(dec_stall),
    .dbg_wr_valid(dbg_wr_valid), .dbg_wr_ready(dbg_wr_ready),
    .dbg_wr_rd(dbg_wr_rd), .dbg_wr_val(dbg_wr_val), .dbg_count(dbg_count),
    .rf_commit(rf_commit), .rf_commit_rd(rf_commit_rd),
    .rf_commit_val(rf_commit_val), .rf_commit_rob_pos(rf_commit_rob_pos),
    .rf_issue(rf_issue), .rf_issue_rd(rf_issue_rd),
    .rf_issue_rob_pos(rf_issue_rob_pos), .rf_rollback(rf_rollback)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Monitor: every commit strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_commit === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_commit_rd", {27'd0, rf_commit_rd}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_rd",  {27'd0, rf_commit_rd},      {27'd0, e.rd});
        chk("commit_val", rf_commit_val,              e.val);
        chk("commit_pos", {28'd0, rf_commit_rob_pos}, {28'd0, e.pos});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; rdy = 1'b1;
    rob_commit = 0; rob_commit_rd = 0; rob_commit_val = 0; rob_commit_pos = 0;
    rob_empty = 1'b1; rollback_req = 0;
    dec_issue = 0; dec_issue_rd = 0; dec_issue_rob_pos = 0;
    dbg_wr_valid = 0; dbg_wr_rd = 0; dbg_wr_val = 0;

    // Reset behaviour
    tick();
    at_neg();
    chk("rst_dec_stall", {31'd0, dec_stall}, 32'd1);
    chk("rst_wr_ready", {31'd0, dbg_wr_ready}, 32'd0);
    chk("rst_rollback", {31'd0, rf_rollback}, 32'd0);
    tick();
    rst = 1'b1;
    at_neg();
    chk("idle_dec_stall", {31'd0, dec_stall}, 32'd0);
    chk("idle_wr_ready", {31'd0, dbg_wr_ready}, 32'd1);
    chk("idle_count", {29'd0, dbg_count}, 32'd0);
    chk("idle_commit", {31'd0, rf_commit}, 32'd0);
    chk("idle_rollback", {31'd0, rf_rollback}, 32'd0);

    // Zero-latency ROB commit forward
    tick();
    exp_q.push_back('{rd: 5'd5, val: 32'hDEADBEEF, pos: 4'd3});
    rob_commit = 1; rob_commit_rd = 5'd5; rob_commit_val = 32'hDEADBEEF; rob_commit_pos = 4'd3;
    at_neg();
    tick();
    rob_commit = 0;

    // Fill the debug FIFO while the ROB is busy
    rob_empty = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      dbg_wr_valid = 1; dbg_wr_rd = 5'(i); dbg_wr_val = 32'(i * 16);
      tick();
    end
    dbg_wr_valid = 0;
    at_neg();
    chk("full_count", {29'd0, dbg_count}, 32'd4);
    chk("full_ready", {31'd0, dbg_wr_ready}, 32'd0);
    chk("full_stall", {31'd0, dec_stall}, 32'd1);
    chk("full_no_drain", {31'd0, rf_commit}, 32'd0);
    for (int i = 1; i <= 4; i++) exp_q.push_back('{rd: 5'(i), val: 32'(i * 16), pos: 4'd0});
    tick();
    rob_empty = 1'b1;
    repeat (4) tick();
    at_neg();
    chk("drained_count", {29'd0, dbg_count}, 32'd0);
    chk("drained_stall", {31'd0, dec_stall}, 32'd0);

    // Rollback pulse and flush window
    tick();
    rollback_req = 1; dec_issue = 1; dec_issue_rd = 5'd7; dec_issue_rob_pos = 4'd9;
    at_neg();
    chk("rb_n_issue", {31'd0, rf_issue}, 32'd0);
    chk("rb_n_stall", {31'd0, dec_stall}, 32'd1);
    chk("rb_n_pulse", {31'd0, rf_rollback}, 32'd0);
    tick();
    rollback_req = 0;
    at_neg();
    chk("rb_n1_pulse", {31'd0, rf_rollback}, 32'd1);
    chk("rb_n1_stall", {31'd0, dec_stall}, 32'd1);
    tick();
    at_neg();
    chk("rb_n2_pulse", {31'd0, rf_rollback}, 32'd0);
    chk("rb_n2_stall", {31'd0, dec_stall}, 32'd1);
    tick();
    at_neg();
    chk("rb_n3_stall", {31'd0, dec_stall}, 32'd1);
    tick();
    at_neg();
    chk("rb_n4_stall", {31'd0, dec_stall}, 32'd0);
    chk("rb_n4_issue", {31'd0, rf_issue}, 32'd1);
    chk("rb_n4_issue_rd", {27'd0, rf_issue_rd}, 32'd7);
    chk("rb_n4_issue_pos", {28'd0, rf_issue_rob_pos}, 32'd9);
    tick();
    dec_issue = 0;

    // Debug write to x0 is accepted but discarded
    dbg_wr_valid = 1; dbg_wr_rd = 5'd0; dbg_wr_val = 32'h55;
    at_neg();
    chk("x0_ready", {31'd0, dbg_wr_ready}, 32'd1);
    tick();
    dbg_wr_valid = 0;
    at_neg();
    chk("x0_count", {29'd0, dbg_count}, 32'd0);
    chk("x0_stall", {31'd0, dec_stall}, 32'd0);

    // Commit + rollback while draining: commit wins, FIFO survives the flush
    tick();
    rob_empty = 1'b0;
    dbg_wr_valid = 1; dbg_wr_rd = 5'd10; dbg_wr_val = 32'hA0;
    tick();
    dbg_wr_rd = 5'd11; dbg_wr_val = 32'hB0;
    tick();
    dbg_wr_valid = 0;
    exp_q.push_back('{rd: 5'd20, val: 32'h12345678, pos: 4'd6});
    rob_commit = 1; rob_commit_rd = 5'd20; rob_commit_val = 32'h12345678; rob_commit_pos = 4'd6;
    rollback_req = 1; rob_empty = 1'b1;
    at_neg();
    chk("mix_count", {29'd0, dbg_count}, 32'd2);
    tick();
    rob_commit = 0; rollback_req = 0;
    at_neg();
    chk("mix_rollback", {31'd0, rf_rollback}, 32'd1);
    chk("mix_rb_count", {29'd0, dbg_count}, 32'd2);
    exp_q.push_back('{rd: 5'd10, val: 32'hA0, pos: 4'd0});
    exp_q.push_back('{rd: 5'd11, val: 32'hB0, pos: 4'd0});
    repeat (3) tick();
    at_neg();
    chk("mix_postflush_count", {29'd0, dbg_count}, 32'd2);
    chk("mix_postflush_stall", {31'd0, dec_stall}, 32'd1);
    repeat (3) tick();
    at_neg();
    chk("mix_done_count", {29'd0, dbg_count}, 32'd0);
    chk("mix_done_stall", {31'd0, dec_stall}, 32'd0);

    // Global-ready freeze in the middle of a drain
    tick();
    rob_empty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dbg_wr_valid = 1; dbg_wr_rd = 5'(12 + i); dbg_wr_val = 32'(8'hC0 + 16 * i);
      exp_q.push_back('{rd: 5'(12 + i), val: 32'(8'hC0 + 16 * i), pos: 4'd0});
      tick();
    end
    dbg_wr_valid = 0;
    rob_empty = 1'b1;
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("frz_commit", {31'd0, rf_commit}, 32'd0);
      chk("frz_stall", {31'd0, dec_stall}, 32'd1);
      chk("frz_count", {29'd0, dbg_count}, 32'd2);
      chk("frz_ready", {31'd0, dbg_wr_ready}, 32'd0);
      tick();
    end
    rdy = 1'b1;
    repeat (2) tick();
    at_neg();
    chk("frz_done_count", {29'd0, dbg_count}, 32'd0);
    chk("frz_done_stall", {31'd0, dec_stall}, 32'd0);

    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_port_sched.md
Name: regfile_port_sched

Overview:
- Controller in front of the register file's write-side ports: commit, issue and rollback.
- Forwards ROB commits with zero latency and highest priority.
- Buffers debug register writes in a small FIFO. It drains them into the commit port only when the ROB is empty and decoder issue is stalled.
- Sequences rollback: one-cycle rollback pulse, then a fixed issue-stall flush window.

Parameters:
- DBG_DEPTH, 4, debug write FIFO entries (power of 2, ≥2).
- FLUSH_CYCLES, 2, issue-stall cycles after the rollback pulse (0 allowed).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- rdy  in  1  global ready; low freezes all state.
- rob_commit  in  1  ROB head commits this cycle.
- rob_commit_rd  in  5  commit destination register.
- rob_commit_val  in  32  commit value.
- rob_commit_pos  in  4  commit ROB position.
- rob_empty  in  1  ROB holds no entries.
- rollback_req  in  1  mispredict rollback request.
- dec_issue  in  1  decoder issue.
- dec_issue_rd  in  5  issue destination register.
- dec_issue_rob_pos  in  4  issue ROB position.
- dec_stall  out  1  decoder must hold issue.
- dbg_wr_valid  in  1  debug write request.
- dbg_wr_ready  out  1  debug FIFO can accept.
- dbg_wr_rd  in  5  debug destination register.
- dbg_wr_val  in  32  debug value.
- dbg_count  out  $clog2(DBG_DEPTH)+1  FIFO occupancy.
- rf_commit  out  1  register file commit strobe.
- rf_commit_rd  out  5  register file commit register.
- rf_commit_val  out  32  register file commit value.
- rf_commit_rob_pos  out  4  register file commit ROB position.
- rf_issue  out  1  register file issue strobe.
- rf_issue_rd  out  5  register file issue register.
- rf_issue_rob_pos  out  4  register file issue ROB position.
- rf_rollback  out  1  register file rollback pulse.

Behaviour:
- States: IDLE, DBG, ROLLBACK, FLUSH. Flush counter is $clog2(FLUSH_CYCLES+1) bits.
- Reset (rst=0 at posedge):
  - state=IDLE, FIFO empty, dbg_count=0, counter=0.
  - While rst=0, all rf_* strobes are 0, dbg_wr_ready=0, dec_stall=1.
- rdy=0: no state, FIFO or counter update. rf_commit, rf_issue, rf_rollback and dbg_wr_ready are forced 0; dec_stall is forced 1.
- Commit path (combinational):
  - If rob_commit=1, rf_commit* mirror rob_commit* in the same cycle, in every state.
  - Otherwise, in state DBG with rob_empty=1 and FIFO non-empty: rf_commit=1, rd/val come from the FIFO head, rf_commit_rob_pos=0, and the head pops at the clock edge.
  - rf_commit_rob_pos=0 can never match a renamed tag, because all tags are clear when the ROB is empty.
- Issue path:
  - dec_stall = (state!=IDLE) | rollback_req | (dbg_count!=0).
  - rf_issue = dec_issue & ~dec_stall; rf_issue_rd and rf_issue_rob_pos pass through unchanged.
- FIFO:
  - dbg_wr_ready = (dbg_count<DBG_DEPTH), based on registered occupancy only.
  - Push on dbg_wr_valid & dbg_wr_ready. Writes with dbg_wr_rd=0 are accepted but not stored.
  - Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DBG_DEPTH.
- Transitions (rollback_req has priority in every state):
  - IDLE: rollback_req → ROLLBACK; otherwise dbg_count!=0 → DBG.
  - DBG: pop as described above. Once a pop empties the FIFO (count 1→0 with no push), go to IDLE next cycle. FIFO contents survive a move to ROLLBACK.
  - ROLLBACK: rf_rollback=1 for exactly this cycle. Load counter=FLUSH_CYCLES. If FLUSH_CYCLES==0 go to IDLE, else go to FLUSH.
  - FLUSH: decrement the counter each cycle; go to IDLE on the cycle the counter reads 1.
- Rollback timing:
  - rf_rollback is a registered-state output: it asserts 1 cycle after rollback_req is sampled.
  - Decoder issue is suppressed in the request cycle itself via the combinational term in dec_stall.
- rollback_req held high for several cycles: each sampled cycle re-enters ROLLBACK, so rf_rollback repeats.
- A ROB commit in the ROLLBACK cycle still passes through. The register file applies the commit, then clears all tags.

Test Plan:
1. Reset held 2 cycles, then release → dec_stall=0, dbg_wr_ready=1, dbg_count=0, rf_* strobes 0.
2. rob_commit=1, rd=5, val=0xDEADBEEF, pos=3 in IDLE → same cycle rf_commit=1, rd=5, val=0xDEADBEEF, rob_pos=3.
3. Push 4 debug writes (rd 1..4, val 0x10..0x40) with rob_empty=0:
   - dbg_count=4, dbg_wr_ready=0, dec_stall=1, no drain.
   - Raise rob_empty → four consecutive rf_commit pulses, rd 1..4, rob_pos=0.
   - IDLE the cycle after the last pop; dec_stall then 0.
4. rollback_req pulse at cycle N with dec_issue=1:
   - rf_issue=0 at N.
   - rf_rollback=1 at N+1 only.
   - dec_stall=1 through N+3; dec_issue passes again at N+4 (FLUSH_CYCLES=2).
5. In DBG state with 2 entries queued, rob_commit=1 and rollback_req=1 in the same cycle:
   - ROB commit forwarded; no pop.
   - Next cycle ROLLBACK with dbg_count=2.
   - After flush, DBG resumes and drains both entries.
6. Mid-drain rdy=0 for 3 cycles → no pops, rf_commit=0, dec_stall=1, dbg_count frozen; drain resumes when rdy=1.
